soc_uart_host: RTL and testbench

// - Host-side controller for the soc_uart core: buffers received and to-be-sent bytes in two FIFOs behind a 4-register bus slave.
// - Drains core RX bytes (rx_full/ack handshake) and feeds core TX bytes (start_tx/tx_empty handshake).
// - Sits between the SoC peripheral bus and soc_uart; clk is the same clock as the core's uclk.

---
 rtl/soc_uart_host_if.sv | 13 +
 rtl/soc_uart_host.sv | 204 ++++++++++++++++++++
 tb/tb_soc_uart_host.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/soc_uart_host_if.sv
// Peripheral bus seen by soc_uart_host: one access per cycle, registered read data.
`timescale 1ns/1ps
interface soc_uart_host_if;
  logic        sel;
  logic        we;
  logic [1:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        rvalid;

  modport master (output sel, we, addr, wdata, input rdata, rvalid);
  modport slave  (input sel, we, addr, wdata, output rdata, rvalid);
endinterface

// File: rtl/soc_uart_host.sv
// Host-side controller for soc_uart: RX/TX byte FIFOs behind a 4-register bus slave,
// draining the core's rx_full/ack handshake and feeding its start_tx/tx_empty handshake.
`timescale 1ns/1ps
module soc_uart_host #(
  parameter int DEPTH = 8
) (
  input  logic              clk,
  input  logic              res_n,
  soc_uart_host_if.slave    bus,
  output logic              irq,
  input  logic              uart_rx_full,
  input  logic [7:0]        uart_rx_data,
  input  logic              uart_rx_overrun,
  input  logic              uart_rx_break,
  output logic              uart_ack,
  input  logic              uart_tx_empty,
  output logic [7:0]        uart_tx_data,
  output logic              uart_start_tx
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [1:0] A_DATA = 2'd0, A_STATUS = 2'd1, A_CLEAR = 2'd2, A_CTRL = 2'd3;

  typedef enum logic {IDLE, REQ} tx_state_e;

  function automatic logic [7:0] sat8(input logic [CW-1:0] c);
    if (int'(c) > 255) return 8'hFF;
    return 8'(c);
  endfunction

  // bus decode
  logic wr, rd, data_wr, data_rd, clr_wr, ctrl_wr;
  assign wr      = bus.sel & bus.we;
  assign rd      = bus.sel & ~bus.we;
  assign data_wr = wr & (bus.addr == A_DATA);
  assign data_rd = rd & (bus.addr == A_DATA);
  assign clr_wr  = wr & (bus.addr == A_CLEAR);
  assign ctrl_wr = wr & (bus.addr == A_CTRL);

  logic unused_wdata;
  assign unused_wdata = ^bus.wdata[31:10];

  // RX FIFO
  logic [7:0]    rx_mem [DEPTH];
  logic [AW-1:0] rx_wp, rx_rp;
  logic [CW-1:0] rx_cnt;
  logic          rx_empty, rx_full, rx_pop, rx_push, rx_flush, rx_take, rx_evt;

  assign rx_empty = (rx_cnt == '0);
  assign rx_full  = (rx_cnt == CW'(DEPTH));
  assign rx_pop   = data_rd & ~rx_empty;
  assign rx_flush = clr_wr & bus.wdata[8];
  // ack is high for one cycle per event, masking the core's still-high rx_full
  assign rx_evt   = ~uart_ack & (uart_rx_full | uart_rx_break);
  assign rx_take  = ~uart_ack & uart_rx_full & ~uart_rx_break;
  assign rx_push  = rx_take & (~rx_full | rx_pop) & ~rx_flush;

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      rx_wp  <= '0;
      rx_rp  <= '0;
      rx_cnt <= '0;
    end else if (rx_flush) begin
      rx_wp  <= '0;
      rx_rp  <= '0;
      rx_cnt <= '0;
    end else begin
      if (rx_push) rx_wp <= rx_wp + 1'b1;
      if (rx_pop)  rx_rp <= rx_rp + 1'b1;
      rx_cnt <= rx_cnt + CW'(rx_push) - CW'(rx_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rx_push) rx_mem[rx_wp] <= uart_rx_data;
  end

  // TX FIFO
  logic [7:0]    tx_mem [DEPTH];
  logic [AW-1:0] tx_wp, tx_rp;
  logic [CW-1:0] tx_cnt;
  logic          tx_empty, tx_full, tx_pop, tx_push, tx_flush;
  tx_state_e     state, state_d;

  assign tx_empty = (tx_cnt == '0);
  assign tx_full  = (tx_cnt == CW'(DEPTH));
  assign tx_pop   = (state == IDLE) & ~tx_empty & uart_tx_empty;
  assign tx_flush = clr_wr & bus.wdata[9];
  assign tx_push  = data_wr & (~tx_full | tx_pop) & ~tx_flush;

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      tx_wp  <= '0;
      tx_rp  <= '0;
      tx_cnt <= '0;
    end else if (tx_flush) begin
      tx_wp  <= '0;
      tx_rp  <= '0;
      tx_cnt <= '0;
    end else begin
      if (tx_push) tx_wp <= tx_wp + 1'b1;
      if (tx_pop)  tx_rp <= tx_rp + 1'b1;
      tx_cnt <= tx_cnt + CW'(tx_push) - CW'(tx_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wp] <= bus.wdata[7:0];
  end

  // TX FSM: REQ is left only once the core drops tx_empty, which rides out its stop-bit phase
  logic       start_d;
  logic [7:0] txd_d;

  always_comb begin
    state_d = state;
    start_d = uart_start_tx;
    txd_d   = uart_tx_data;
    case (state)
      IDLE: if (tx_pop) begin
        state_d = REQ;
        start_d = 1'b1;
        txd_d   = tx_mem[tx_rp];
      end
      REQ: if (!uart_tx_empty) begin
        state_d = IDLE;
        start_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      state         <= IDLE;
      uart_start_tx <= 1'b0;
      uart_tx_data  <= 8'h00;
    end else begin
      state         <= state_d;
      uart_start_tx <= start_d;
      uart_tx_data  <= txd_d;
    end
  end

  // sticky flags: a same-cycle set beats a clear
  logic ovr, brk, drop, ovr_set, brk_set, drop_set;
  logic [2:0] ctrl;

  assign ovr_set  = ~uart_ack & uart_rx_full &
                    (uart_rx_overrun | (~uart_rx_break & rx_full & ~rx_pop));
  assign brk_set  = ~uart_ack & uart_rx_break;
  assign drop_set = data_wr & tx_full & ~tx_pop;

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      ovr      <= 1'b0;
      brk      <= 1'b0;
      drop     <= 1'b0;
      ctrl     <= 3'b000;
      uart_ack <= 1'b0;
      irq      <= 1'b0;
    end else begin
      ovr      <= ovr_set  | (ovr  & ~(clr_wr & bus.wdata[4]));
      brk      <= brk_set  | (brk  & ~(clr_wr & bus.wdata[5]));
      drop     <= drop_set | (drop & ~(clr_wr & bus.wdata[6]));
      if (ctrl_wr) ctrl <= bus.wdata[2:0];
      uart_ack <= rx_evt;
      irq      <= (ctrl[0] & ~rx_empty) | (ctrl[1] & tx_empty) | (ctrl[2] & (ovr | brk | drop));
    end
  end

  // read path
  logic        tx_idle;
  logic [31:0] status, rdata_d, rdata_q;
  logic        rvalid_q;

  assign tx_idle = tx_empty & (state == IDLE) & uart_tx_empty;
  assign status  = {sat8(tx_cnt), sat8(rx_cnt), 8'h00,
                    tx_idle, drop, brk, ovr, tx_full, tx_empty, rx_full, ~rx_empty};

  always_comb begin
    rdata_d = 32'h0;
    case (bus.addr)
      A_DATA:   rdata_d = rx_empty ? 32'h0 : {23'b0, 1'b1, rx_mem[rx_rp]};
      A_STATUS: rdata_d = status;
      A_CLEAR:  rdata_d = 32'h0;
      A_CTRL:   rdata_d = {29'b0, ctrl};
      default:  rdata_d = 32'h0;
    endcase
  end

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      rdata_q  <= 32'h0;
      rvalid_q <= 1'b0;
    end else begin
      rvalid_q <= rd;
      if (rd) rdata_q <= rdata_d;
    end
  end

  assign bus.rdata  = rdata_q;
  assign bus.rvalid = rvalid_q;
endmodule

// File: tb/tb_soc_uart_host.sv
// Directed bench for soc_uart_host: bus accesses plus a hand-driven core model, expectations hand-computed.
`timescale 1ns/1ps
module tb_soc_uart_host;
  logic       clk = 1'b0;
  logic       res_n = 1'b0;
  logic       irq, uart_ack, uart_start_tx;
  logic       uart_rx_full = 1'b0, uart_rx_overrun = 1'b0, uart_rx_break = 1'b0;
  logic       uart_tx_empty = 1'b1;
  logic [7:0] uart_rx_data = 8'h00;
  logic [7:0] uart_tx_data;
  int         n_chk = 0, n_err = 0;
  logic [31:0] rd_val;

  soc_uart_host_if bif ();

  soc_uart_host #(.DEPTH(8)) dut (
    .clk(clk), .res_n(res_n), .bus(bif.slave), .irq(irq),
    .uart_rx_full(uart_rx_full), .uart_rx_data(uart_rx_data),
    .uart_rx_overrun(uart_rx_overrun), .uart_rx_break(uart_rx_break),
    .uart_ack(uart_ack), .uart_tx_empty(uart_tx_empty),
    .uart_tx_data(uart_tx_data), .uart_start_tx(uart_start_tx)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic bus_wr(input logic [1:0] a, input logic [31:0] d);
    bif.sel = 1'b1; bif.we = 1'b1; bif.addr = a; bif.wdata = d;
    tick();
    bif.sel = 1'b0; bif.we = 1'b0;
  endtask

  task automatic bus_rd(input logic [1:0] a, output logic [31:0] d);
    bif.sel = 1'b1; bif.we = 1'b0; bif.addr = a;
    tick();
    bif.sel = 1'b0;
    chk("rvalid", {31'b0, bif.rvalid}, 32'h1);
    d = bif.rdata;
  endtask

  // core presents one byte and drops rx_full once it sees ack
  task automatic rx_byte(input logic [7:0] d);
    uart_rx_data = d; uart_rx_full = 1'b1;
    tick();
    chk("rx_ack_hi", {31'b0, uart_ack}, 32'h1);
    uart_rx_full = 1'b0;
    tick();
    chk("rx_ack_lo", {31'b0, uart_ack}, 32'h0);
  endtask

  initial begin
    bif.sel = 1'b0; bif.we = 1'b0; bif.addr = 2'd0; bif.wdata = 32'h0;
    #12;
    chk("rst_rdata",  bif.rdata, 32'h0);
    chk("rst_rvalid", {31'b0, bif.rvalid}, 32'h0);
    chk("rst_irq",    {31'b0, irq}, 32'h0);
    chk("rst_ack",    {31'b0, uart_ack}, 32'h0);
    chk("rst_start",  {31'b0, uart_start_tx}, 32'h0);
    chk("rst_txdata", {24'b0, uart_tx_data}, 32'h0);
    @(negedge clk); res_n = 1'b1;
    tick();

    // RX path
    rx_byte(8'h41);
    rx_byte(8'h42);
    bus_rd(2'd1, rd_val); chk("rx_status2", rd_val, 32'h0002_0085);
    bus_rd(2'd0, rd_val); chk("rx_data0",   rd_val, 32'h0000_0141);
    bus_rd(2'd0, rd_val); chk("rx_data1",   rd_val, 32'h0000_0142);
    bus_rd(2'd0, rd_val); chk("rx_empty",   rd_val, 32'h0000_0000);

    // RX overrun: ninth byte discarded
    for (int i = 0; i < 9; i++) rx_byte(8'h10 + 8'(i));
    bus_rd(2'd1, rd_val); chk("ovr_status", rd_val, 32'h0008_0097);
    bus_wr(2'd2, 32'h10);
    bus_rd(2'd1, rd_val); chk("ovr_clear",  rd_val, 32'h0008_0087);
    bus_rd(2'd0, rd_val); chk("ovr_first",  rd_val, 32'h0000_0110);
    bus_rd(2'd1, rd_val); chk("ovr_cnt7",   rd_val, 32'h0007_0085);
    bus_wr(2'd2, 32'h100);
    bus_rd(2'd1, rd_val); chk("rx_flush",   rd_val, 32'h0000_0084);

    // TX path with a lingering tx_empty after the stop bit
    bus_wr(2'd0, 32'h55);
    chk("tx_lat_lo", {31'b0, uart_start_tx}, 32'h0);
    bus_wr(2'd0, 32'hAA);
    chk("tx_start55", {31'b0, uart_start_tx}, 32'h1);
    chk("tx_data55",  {24'b0, uart_tx_data}, 32'h55);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("tx_hold_start", {31'b0, uart_start_tx}, 32'h1);
      chk("tx_hold_data",  {24'b0, uart_tx_data}, 32'h55);
    end
    uart_tx_empty = 1'b0;
    tick(); chk("tx_accept",  {31'b0, uart_start_tx}, 32'h0);
    tick(); chk("tx_busy",    {31'b0, uart_start_tx}, 32'h0);
    uart_tx_empty = 1'b1;
    tick(); chk("tx_startAA", {31'b0, uart_start_tx}, 32'h1);
    chk("tx_dataAA", {24'b0, uart_tx_data}, 32'hAA);
    uart_tx_empty = 1'b0;
    tick(); chk("tx_acceptAA", {31'b0, uart_start_tx}, 32'h0);
    uart_tx_empty = 1'b1;
    tick(); chk("tx_no_more", {31'b0, uart_start_tx}, 32'h0);
    bus_rd(2'd1, rd_val); chk("tx_idle_st", rd_val, 32'h0000_0084);

    // TX full with stalled core, then flush
    uart_tx_empty = 1'b0;
    for (int i = 0; i < 9; i++) bus_wr(2'd0, 32'(i));
    bus_rd(2'd1, rd_val); chk("txf_status", rd_val, 32'h0800_0048);
    bus_wr(2'd2, 32'h200);
    bus_rd(2'd1, rd_val); chk("txf_flush",  rd_val, 32'h0000_0044);
    uart_tx_empty = 1'b1;
    tick(); chk("txf_nostart0", {31'b0, uart_start_tx}, 32'h0);
    tick(); chk("txf_nostart1", {31'b0, uart_start_tx}, 32'h0);
    bus_rd(2'd1, rd_val); chk("txf_idle",   rd_val, 32'h0000_00C4);
    bus_wr(2'd2, 32'h40);
    bus_rd(2'd1, rd_val); chk("txf_clrdrop", rd_val, 32'h0000_0084);

    // break with err_ie
    bus_wr(2'd3, 32'hFFFF_FFFC);
    bus_rd(2'd3, rd_val); chk("ctrl_rd", rd_val, 32'h4);
    uart_rx_break = 1'b1;
    tick(); chk("brk_ack", {31'b0, uart_ack}, 32'h1);
    uart_rx_break = 1'b0;
    tick(); chk("brk_ack_lo", {31'b0, uart_ack}, 32'h0);
    chk("brk_irq", {31'b0, irq}, 32'h1);
    bus_rd(2'd1, rd_val); chk("brk_status", rd_val, 32'h0000_00A4);
    bus_rd(2'd0, rd_val); chk("brk_nopush", rd_val, 32'h0);
    bus_wr(2'd2, 32'h20);
    tick(); chk("brk_irq_clr", {31'b0, irq}, 32'h0);

    // reset while in REQ
    bus_wr(2'd3, 32'h1);
    rx_byte(8'h5A);
    chk("rxie_irq", {31'b0, irq}, 32'h1);
    bus_wr(2'd0, 32'h33);
    tick();
    chk("req_start", {31'b0, uart_start_tx}, 32'h1);
    chk("req_data",  {24'b0, uart_tx_data}, 32'h33);
    res_n = 1'b0;
    #2;
    chk("arst_start",  {31'b0, uart_start_tx}, 32'h0);
    chk("arst_txdata", {24'b0, uart_tx_data}, 32'h0);
    chk("arst_irq",    {31'b0, irq}, 32'h0);
    @(negedge clk); res_n = 1'b1;
    tick();
    bus_rd(2'd1, rd_val); chk("arst_status", rd_val, 32'h0000_0084);
    bus_rd(2'd3, rd_val); chk("arst_ctrl",   rd_val, 32'h0);
    bus_rd(2'd0, rd_val); chk("arst_data",   rd_val, 32'h0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
